// File: rtl/msr_pkg.sv
// Shared types and default limits for the multi-channel measurement capture block.
package msr_pkg;

  typedef enum logic [0:0] {
    MSR_IDLE  = 1'b0,
    MSR_READY = 1'b1
  } msr_state_e;

  localparam int MSR_TIMER_W_DEF = 24;
  localparam int MSR_TIMER_W_MIN = 8;
  localparam int MSR_TIMER_W_MAX = 32;
  localparam int MSR_NCH_DEF     = 4;
  localparam int MSR_NCH_MAX     = 16;
  localparam int MSR_SYNC_MIN    = 2;
  localparam int MSR_SYNC_MAX    = 4;
  localparam int MSR_EPOCH_W_DEF = 8;

  // Next-state for the timer: clear wins over increment, all-ones rolls to zero.
  function automatic logic [MSR_TIMER_W_MAX-1:0] msr_timer_next(
    input logic [MSR_TIMER_W_MAX-1:0] cur,
    input logic                       clr
  );
    logic [MSR_TIMER_W_MAX-1:0] nxt;
    if (clr) begin
      nxt = {MSR_TIMER_W_MAX{1'b0}};
    end else begin
      nxt = cur + {{(MSR_TIMER_W_MAX-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/msr_req_sync.sv
// Request-line synchroniser: SYNC_STAGES flop chain plus one history flop
// giving single-cycle rise/fall strobes on the synchronised level.
module msr_req_sync
  import msr_pkg::*;
#(
  parameter int SYNC_STAGES = MSR_SYNC_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_async,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;
  logic                   hist_q;
  logic                   hist_d;

  // Shift the raw request in at bit 0; the MSB is the synchronised level.
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], req_async};
    hist_d  = chain_q[SYNC_STAGES-1];
  end

  // Chain and history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {SYNC_STAGES{1'b0}};
      hist_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      hist_q  <= hist_d;
    end
  end

  assign sync_out = chain_q[SYNC_STAGES-1];
  assign rise     = chain_q[SYNC_STAGES-1] & ~hist_q;
  assign fall     = ~chain_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/msr_capture_multi.sv
// Free-running timer captured independently per request channel with a 4-phase
// ready handshake. Define MSR_EPOCH_EN to add a wrap counter captured per channel.
module msr_capture_multi
  import msr_pkg::*;
#(
  parameter int TIMER_W     = MSR_TIMER_W_DEF,
  parameter int NCH         = MSR_NCH_DEF,
  parameter int SYNC_STAGES = MSR_SYNC_MIN
`ifdef MSR_EPOCH_EN
  ,
  parameter int EPOCH_W     = MSR_EPOCH_W_DEF
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           data_req,
  input  logic                     timer_clr,
  output logic [NCH-1:0]           data_rdy,
  output logic [NCH*TIMER_W-1:0]   msr_data,
  output logic [NCH-1:0]           wrap_seen
`ifdef MSR_EPOCH_EN
  ,
  output logic [NCH*EPOCH_W-1:0]   msr_epoch
`endif
);

  logic [TIMER_W-1:0]       timer_q;
  logic [TIMER_W-1:0]       timer_d;
  logic [MSR_TIMER_W_MAX-1:0] timer_ext_s;
  logic [MSR_TIMER_W_MAX-1:0] timer_nxt_s;
  logic                     wrap_s;

  logic [NCH-1:0]           sync_s;
  logic [NCH-1:0]           rise_s;
  logic [NCH-1:0]           fall_s;

  msr_state_e               state_q [NCH];
  msr_state_e               state_d [NCH];
  logic [NCH-1:0]           rdy_q;
  logic [NCH-1:0]           rdy_d;
  logic [NCH-1:0]           pend_q;
  logic [NCH-1:0]           pend_d;
  logic [NCH-1:0]           wrap_seen_q;
  logic [NCH-1:0]           wrap_seen_d;
  logic [NCH*TIMER_W-1:0]   msr_data_q;
  logic [NCH*TIMER_W-1:0]   msr_data_d;

  // Wrap is the all-ones to zero roll; a clear is never counted as one.
  always_comb begin
    timer_ext_s = {MSR_TIMER_W_MAX{1'b0}};
    timer_ext_s[TIMER_W-1:0] = timer_q;
    timer_nxt_s = msr_timer_next(timer_ext_s, timer_clr);
    timer_d     = timer_nxt_s[TIMER_W-1:0];
    if (timer_clr) begin
      wrap_s = 1'b0;
    end else begin
      wrap_s = &timer_q;
    end
  end

  // Timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= {TIMER_W{1'b0}};
    end else begin
      timer_q <= timer_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_sync
    msr_req_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_async (data_req[g]),
      .sync_out  (sync_s[g]),
      .rise      (rise_s[g]),
      .fall      (fall_s[g])
    );
  end

`ifdef MSR_EPOCH_EN
  logic [EPOCH_W-1:0]       epoch_q;
  logic [EPOCH_W-1:0]       epoch_d;
  logic [NCH*EPOCH_W-1:0]   msr_epoch_q;
  logic [NCH*EPOCH_W-1:0]   msr_epoch_d;

  // Wrap counter follows the timer clear, otherwise counts wraps modulo 2^EPOCH_W.
  always_comb begin
    if (timer_clr) begin
      epoch_d = {EPOCH_W{1'b0}};
    end else if (wrap_s) begin
      epoch_d = epoch_q + {{(EPOCH_W-1){1'b0}}, 1'b1};
    end else begin
      epoch_d = epoch_q;
    end
  end

  // Per-channel epoch capture uses the same rise strobe as the timer capture.
  always_comb begin
    msr_epoch_d = msr_epoch_q;
    for (int i = 0; i < NCH; i++) begin
      if ((state_q[i] == MSR_IDLE) && rise_s[i]) begin
        msr_epoch_d[i*EPOCH_W +: EPOCH_W] = epoch_q;
      end else begin
        msr_epoch_d[i*EPOCH_W +: EPOCH_W] = msr_epoch_q[i*EPOCH_W +: EPOCH_W];
      end
    end
  end

  // Wrap counter and captured epochs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch_q     <= {EPOCH_W{1'b0}};
      msr_epoch_q <= {(NCH*EPOCH_W){1'b0}};
    end else begin
      epoch_q     <= epoch_d;
      msr_epoch_q <= msr_epoch_d;
    end
  end

  assign msr_epoch = msr_epoch_q;
`endif

  // Per-channel handshake FSM; a wrap on the capture edge re-arms pending.
  always_comb begin
    rdy_d       = rdy_q;
    wrap_seen_d = wrap_seen_q;
    msr_data_d  = msr_data_q;
    pend_d      = pend_q | {NCH{wrap_s}};
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        MSR_IDLE: begin
          if (rise_s[i]) begin
            state_d[i]                        = MSR_READY;
            rdy_d[i]                          = 1'b1;
            wrap_seen_d[i]                    = pend_q[i];
            pend_d[i]                         = wrap_s;
            msr_data_d[i*TIMER_W +: TIMER_W]  = timer_q;
          end else begin
            rdy_d[i] = 1'b0;
          end
        end
        MSR_READY: begin
          // A low synchronised level in READY also returns to IDLE.
          if (fall_s[i] || !sync_s[i]) begin
            state_d[i] = MSR_IDLE;
            rdy_d[i]   = 1'b0;
          end else begin
            rdy_d[i] = 1'b1;
          end
        end
        default: begin
          state_d[i] = MSR_IDLE;
          rdy_d[i]   = 1'b0;
        end
      endcase
    end
  end

  // Channel state, handshake and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= MSR_IDLE;
      end
      rdy_q       <= {NCH{1'b0}};
      pend_q      <= {NCH{1'b0}};
      wrap_seen_q <= {NCH{1'b0}};
      msr_data_q  <= {(NCH*TIMER_W){1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
      end
      rdy_q       <= rdy_d;
      pend_q      <= pend_d;
      wrap_seen_q <= wrap_seen_d;
      msr_data_q  <= msr_data_d;
    end
  end

  assign data_rdy  = rdy_q;
  assign msr_data  = msr_data_q;
  assign wrap_seen = wrap_seen_q;

endmodule

// File: tb/tb_msr_capture_multi.sv
// Scoreboard bench for msr_capture_multi (TIMER_W=8, NCH=2, SYNC_STAGES=2);
// epoch checks are compiled in when MSR_EPOCH_EN is defined.
module tb_msr_capture_multi;

  localparam int TW = 8;
  localparam int NC = 2;
  localparam int SS = 2;
  localparam int EW = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           timer_clr = 1'b0;
  logic [NC-1:0]  data_req = '0;
  logic [NC-1:0]  data_rdy;
  logic [NC-1:0]  wrap_seen;
  logic [NC*TW-1:0] msr_data;
`ifdef MSR_EPOCH_EN
  logic [NC*EW-1:0] msr_epoch;
`endif

  always #5 clk = ~clk;

  msr_capture_multi #(
    .TIMER_W     (TW),
    .NCH         (NC),
    .SYNC_STAGES (SS)
`ifdef MSR_EPOCH_EN
    ,
    .EPOCH_W     (EW)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_req  (data_req),
    .timer_clr (timer_clr),
    .data_rdy  (data_rdy),
    .msr_data  (msr_data),
    .wrap_seen (wrap_seen)
`ifdef MSR_EPOCH_EN
    ,
    .msr_epoch (msr_epoch)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference timer: visible value, total wraps since reset, wraps since clear.
  logic [TW-1:0] m_tmr;
  int            m_wraps;
  logic [EW-1:0] m_epoch;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tmr   <= '0;
      m_wraps <= 0;
      m_epoch <= '0;
    end else if (timer_clr) begin
      m_tmr   <= '0;
      m_epoch <= '0;
    end else begin
      m_tmr <= m_tmr + 8'd1;
      if (m_tmr == 8'hFF) begin
        m_wraps <= m_wraps + 1;
        m_epoch <= m_epoch + 8'd1;
      end
    end
  end

  typedef struct {
    int            ch;
    logic [TW-1:0] data;
    logic          ws;
    logic [EW-1:0] ep;
  } exp_t;

  exp_t          sbq[$];
  int            last_cap [NC];
  logic [TW-1:0] last_data [NC];

  // Raise the masked requests at a negedge and predict the capture two
  // edges after the sampling edge; then check latency and pop the scoreboard.
  task automatic capture(input logic [NC-1:0] mask);
    exp_t e;
    int   wpre;
    wpre = m_wraps + ((m_tmr == 8'hFF) ? 1 : 0) + ((m_tmr == 8'hFE) ? 1 : 0);
    for (int c = 0; c < NC; c++) begin
      if (mask[c]) begin
        e.ch   = c;
        e.data = m_tmr + 8'd2;
        e.ws   = (wpre != last_cap[c]);
        e.ep   = m_epoch + EW'(wpre - m_wraps);
        last_cap[c] = wpre;
        sbq.push_back(e);
      end
    end
    data_req = data_req | mask;
    repeat (SS) @(negedge clk);
    chk("rdy_before_latency", 32'(data_rdy & mask), 32'(0));
    @(negedge clk);
    chk("rdy_at_latency", 32'(data_rdy & mask), 32'(mask));
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("msr_data[%0d]", e.ch), 32'(msr_data[e.ch*TW +: TW]), 32'(e.data));
      chk($sformatf("wrap_seen[%0d]", e.ch), 32'(wrap_seen[e.ch]), 32'(e.ws));
`ifdef MSR_EPOCH_EN
      chk($sformatf("msr_epoch[%0d]", e.ch), 32'(msr_epoch[e.ch*EW +: EW]), 32'(e.ep));
`endif
      last_data[e.ch] = e.data;
    end
  endtask

  task automatic release_req(input logic [NC-1:0] mask);
    data_req = data_req & ~mask;
    repeat (SS) @(negedge clk);
    chk("rdy_hold_after_drop", 32'(data_rdy & mask), 32'(mask));
    @(negedge clk);
    chk("rdy_fall", 32'(data_rdy & mask), 32'(0));
    for (int c = 0; c < NC; c++) begin
      if (mask[c]) chk("data_kept_after_fall", 32'(msr_data[c*TW +: TW]), 32'(last_data[c]));
    end
    @(negedge clk);
  endtask

  task automatic wait_tmr(input logic [TW-1:0] t);
    int k;
    k = 0;
    while (m_tmr != t && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (m_tmr != t) chk("wait_tmr_timeout", 32'(m_tmr), 32'(t));
  endtask

  task automatic wait_wraps(input int target);
    int k;
    k = 0;
    while (m_wraps < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (m_wraps < target) chk("wait_wraps_timeout", 32'(m_wraps), 32'(target));
  endtask

  initial begin
    int w0;
    for (int c = 0; c < NC; c++) begin
      last_cap[c]  = 0;
      last_data[c] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_rdy", 32'(data_rdy), 32'(0));
    chk("reset_data", 32'(msr_data), 32'(0));
    chk("reset_wrap_seen", 32'(wrap_seen), 32'(0));
    rst_n = 1'b1;

    // Basic: request at timer 0x10 captures 0x12, channel 1 untouched.
    wait_tmr(8'h10);
    capture(2'b01);
    chk("basic_value", 32'(msr_data[0 +: TW]), 32'h12);
    chk("ch1_idle", 32'(data_rdy[1]), 32'(0));

    // Handshake: hold 20 cycles with stable capture, drop, then recapture.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("hold_rdy", 32'(data_rdy[0]), 32'(1));
      chk("hold_data", 32'(msr_data[0 +: TW]), 32'(last_data[0]));
    end
    release_req(2'b01);
    capture(2'b01);
    release_req(2'b01);

    // Capture on the wrap edge itself: no wrap yet, pending re-armed.
    wait_tmr(8'hFD);
    capture(2'b11);
    release_req(2'b11);
    // Capture one cycle after a wrap: post-wrap 0x00 with wrap_seen.
    wait_tmr(8'hFE);
    capture(2'b11);
    chk("both_post_wrap", 32'(msr_data), 32'(0));
    release_req(2'b11);
    wait_tmr(8'h20);
    capture(2'b10);
    release_req(2'b10);

    // timer_clr at 0x80: capture counts from the clear, no wrap reported.
    wait_tmr(8'h80);
    timer_clr = 1'b1;
    @(negedge clk);
    timer_clr = 1'b0;
    repeat (5) @(negedge clk);
    capture(2'b01);
    chk("clr_elapsed", 32'(msr_data[0 +: TW]), 32'd7);
    chk("clr_not_wrap", 32'(wrap_seen[0]), 32'(0));
    release_req(2'b01);

    // Three full wraps since the clear, then request.
    w0 = m_wraps;
    wait_wraps(w0 + 3);
    repeat (4) @(negedge clk);
    capture(2'b01);
`ifdef MSR_EPOCH_EN
    chk("epoch_three", 32'(msr_epoch[0 +: EW]), 32'd3);
`endif

    // Async reset while channel 0 is READY and request still held.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rdy", 32'(data_rdy), 32'(0));
    chk("async_rst_data", 32'(msr_data), 32'(0));
    chk("async_rst_wrap", 32'(wrap_seen), 32'(0));
`ifdef MSR_EPOCH_EN
    chk("async_rst_epoch", 32'(msr_epoch), 32'(0));
`endif
    for (int c = 0; c < NC; c++) last_cap[c] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    capture(2'b01);
    chk("post_reset_value", 32'(msr_data[0 +: TW]), 32'h02);
    release_req(2'b01);

    chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
